instr_fetch_unit: RTL and testbench

Instruction fetch stage for the MIPS datapath. Holds the program counter, runs a request/acknowledge handshake with instruction memory, and presents each fetched 32-bit word plus its PC in a registered IF/ID slot. The slot's `instrWord` is the word the control decoder consumes. Supports downstream stall, and branch/jump redirect with correct squashing of in-flight fetches.

---
 rtl/instr_fetch_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS instruction fetch stage.
// Holds the PC, runs a req/ack handshake with instruction memory, and presents
// each fetched word with its PC in a registered IF/ID slot. A one-entry skid
// register absorbs a fetch that completes while the slot is stalled. Redirects
// squash younger work; an unacked request at redirect time is completed at its
// stale address (DISCARD) so the handshake stays stable.
// Optional macro IFETCH_PERF_CNT_EN adds fetchCount/stallCount counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] instrWord,
  output logic [31:0] instrPc,
`ifdef IFETCH_PERF_CNT_EN
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount,
`endif
  output logic        instrValid
);

  typedef enum logic [1:0] {START, REQ, SKID, DISCARD} state_t;

  state_t      state, next_state;
  logic [31:0] pc;
  logic [31:0] target_pc;
  logic [31:0] skid_word_p0;
  logic [31:0] skid_pc_p0;
  logic        skid_vld_p0;

  logic        ack;
  logic        out_free;
  logic        load_slot;
  logic        load_skid;
  logic        fetch_done;
  logic        hold_pc;

  // Address always tracks the PC; during DISCARD the PC still holds the stale
  // address and the redirect target waits in target_pc.
  assign imemAddr = pc;
  assign out_free = !instrValid || !stall;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= START;
    else        state <= next_state;
  end

  // Next-state, request output and datapath strobes.
  always_comb begin
    next_state = state;
    imemReq    = 1'b0;
    ack        = 1'b0;
    load_slot  = 1'b0;
    load_skid  = 1'b0;
    fetch_done = 1'b0;
    hold_pc    = 1'b0;
    case (state)
      START: begin
        next_state = REQ;
      end
      REQ: begin
        imemReq = 1'b1;
        ack     = imemAck;
        if (redirect) begin
          // Unacked request must finish at its stale address first.
          next_state = imemAck ? REQ : DISCARD;
          hold_pc    = !imemAck;
        end else if (imemAck) begin
          fetch_done = 1'b1;
          if (out_free) begin
            load_slot = 1'b1;
          end else begin
            load_skid  = 1'b1;
            next_state = SKID;
          end
        end
      end
      SKID: begin
        if (redirect) begin
          next_state = REQ;
        end else if (out_free) begin
          load_slot  = skid_vld_p0;
          next_state = REQ;
        end
      end
      DISCARD: begin
        imemReq = 1'b1;
        ack     = imemAck;
        if (imemAck) next_state = REQ;
        else         hold_pc    = redirect;
      end
      default: next_state = START;
    endcase
  end

  // Program counter and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      target_pc <= RESET_PC;
    end else if (redirect) begin
      if (hold_pc) target_pc <= redirectPc;
      else         pc        <= redirectPc;
    end else if (fetch_done) begin
      pc <= pc + 32'd4;
    end else if (state == DISCARD && ack) begin
      pc <= target_pc;
    end
  end

  // IF/ID slot: load from memory or from the skid, else empty when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrWord  <= '0;
      instrPc    <= '0;
      instrValid <= 1'b0;
    end else if (redirect) begin
      instrValid <= 1'b0;
    end else if (load_slot) begin
      instrWord  <= (state == SKID) ? skid_word_p0 : imemData;
      instrPc    <= (state == SKID) ? skid_pc_p0   : pc;
      instrValid <= 1'b1;
    end else if (out_free) begin
      instrValid <= 1'b0;
    end
  end

  // Skid register: parks a word that arrives while the slot is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_word_p0 <= '0;
      skid_pc_p0   <= '0;
      skid_vld_p0  <= 1'b0;
    end else if (redirect) begin
      skid_vld_p0 <= 1'b0;
    end else if (load_skid) begin
      skid_word_p0 <= imemData;
      skid_pc_p0   <= pc;
      skid_vld_p0  <= 1'b1;
    end else if (state == SKID && out_free) begin
      skid_vld_p0 <= 1'b0;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Performance counters: slot loads and stalled-valid cycles, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (load_slot && !redirect) fetchCount <= fetchCount + 32'd1;
      if (instrValid && stall)    stallCount <= stallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scoreboard bench for instr_fetch_unit.
// Stimulus pushes the PC of each instruction expected to be consumed; a
// negedge monitor pops and compares on every slot consumption.
module tb_instr_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] instrWord;
  logic [31:0] instrPc;
  logic        instrValid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  instr_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
    .instrWord(instrWord), .instrPc(instrPc),
`ifdef IFETCH_PERF_CNT_EN
    .fetchCount(fetchCount), .stallCount(stallCount),
`endif
    .instrValid(instrValid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // Instruction memory: data follows the address; ack is bench-controlled.
  assign imemData = mem_word(imemAddr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    imemAck = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    step(); step();
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Monitor: every consumption (valid && !stall) must match the queue head.
  always @(negedge clk) begin
    if (rst_n && instrValid && !stall) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got pc %h with empty queue", instrPc);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_pc", instrPc, e);
        chk("sb_word", instrWord, mem_word(e));
      end
    end
  end

  initial begin
    rst_n = 1'b1; imemAck = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", {31'd0, imemReq}, 32'd0);
    chk("rst_addr", imemAddr, RPC);
    chk("rst_word", instrWord, 32'd0);
    chk("rst_pc", instrPc, 32'd0);
    chk("rst_valid", {31'd0, instrValid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst_fcnt", fetchCount, 32'd0);
    chk("rst_scnt", stallCount, 32'd0);
`endif

    // T1: ack tied high, back-to-back fetches.
    do_reset();
    imemAck = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(RPC + 32'(4 * i));
    step();
    chk("t1_first_req", {31'd0, imemReq}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_valid", {31'd0, instrValid}, 32'd1);
    end
    imemAck = 1'b0;
    drain("t1_drain");

    // T2: ack delayed 3 cycles on 0x0040_0004.
    do_reset();
    sb.push_back(RPC); sb.push_back(RPC + 32'd4);
    step();
    imemAck = 1'b1;
    step();
    imemAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step();
      chk("t2_addr_held", imemAddr, RPC + 32'd4);
      chk("t2_req_held", {31'd0, imemReq}, 32'd1);
    end
    imemAck = 1'b1;
    step();
    imemAck = 1'b0;
    chk("t2_addr_next", imemAddr, RPC + 32'd8);
    step();
    chk("t2_no_dup", {31'd0, instrValid}, 32'd0);
    drain("t2_drain");

    // T3: stall 4 cycles with ack high; one word parks in skid.
    do_reset();
    imemAck = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(RPC + 32'(4 * i));
    step(); step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_word_held", instrWord, mem_word(RPC));
      chk("t3_req_low", {31'd0, imemReq}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("t3_skid_pc", instrPc, RPC + 32'd4);
    chk("t3_req_after", imemAddr, RPC + 32'd8);
    step(); step();
    imemAck = 1'b0;
    drain("t3_drain");

    // T4: redirect while REQ at 0x0040_0010 is unacked; ack two cycles later.
    do_reset();
    imemAck = 1'b1;
    for (int i = 0; i < 4; i++) sb.push_back(RPC + 32'(4 * i));
    sb.push_back(32'h0040_0100);
    repeat (5) step();
    imemAck = 1'b0;
    step();
    chk("t4_pending", imemAddr, 32'h0040_0010);
    redirect = 1'b1; redirectPc = 32'h0040_0100;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i != 0) step();
      chk("t4_stale_addr", imemAddr, 32'h0040_0010);
      chk("t4_stale_req", {31'd0, imemReq}, 32'd1);
      chk("t4_squash", {31'd0, instrValid}, 32'd0);
    end
    imemAck = 1'b1;
    step();
    chk("t4_new_addr", imemAddr, 32'h0040_0100);
    chk("t4_dropped", {31'd0, instrValid}, 32'd0);
    step();
    imemAck = 1'b0;
    chk("t4_first_pc", instrPc, 32'h0040_0100);
    drain("t4_drain");

    // T5: redirect with stall high and full skid.
    do_reset();
    imemAck = 1'b1;
    sb.push_back(32'h0040_0200);
    step(); step();
    stall = 1'b1;
    step();
    redirect = 1'b1; redirectPc = 32'h0040_0200;
    step();
    redirect = 1'b0; stall = 1'b0;
    chk("t5_cleared", {31'd0, instrValid}, 32'd0);
    chk("t5_req", {31'd0, imemReq}, 32'd1);
    chk("t5_addr", imemAddr, 32'h0040_0200);
    step();
    imemAck = 1'b0;
    chk("t5_pc", instrPc, 32'h0040_0200);
    drain("t5_drain");

    // T6: PC wrap at 0xFFFF_FFFC, then async reset mid-request.
    do_reset();
    step();
    imemAck = 1'b1; redirect = 1'b1; redirectPc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("t6_addr", imemAddr, 32'hFFFF_FFFC);
    chk("t6_ack_drop", {31'd0, instrValid}, 32'd0);
    sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0000_0000);
    step();
    chk("t6_wrap", imemAddr, 32'h0000_0000);
    step();
    imemAck = 1'b0;
    step();
    chk("t6_midreq", imemAddr, 32'h0000_0004);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req", {31'd0, imemReq}, 32'd0);
    chk("t6_rst_addr", imemAddr, RPC);
    chk("t6_rst_word", instrWord, 32'd0);
    chk("t6_rst_pc", instrPc, 32'd0);
    chk("t6_rst_valid", {31'd0, instrValid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
    chk("t6_rst_fcnt", fetchCount, 32'd0);
    chk("t6_rst_scnt", stallCount, 32'd0);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
